button_event_classifier: RTL and testbench
==========================================

BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50_000_000, meaning hold time in cycles that qualifies a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 12_500_000, meaning the maximum release-to-press gap in cycles for a double click (250 ms).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning the auto-repeat period in cycles (used only when REQ-030 is enabled).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port button_pressed, input, 1 bit: debounced level from the debounce stage, synchronous to clk, 1 = held.
REQ-007 SHALL have port event_valid, output, 1 bit: an event is held in the output register.
REQ-008 SHALL have port event_code, output, 2 bits: 01 = single, 10 = double, 11 = long; 00 is never presented while valid.
REQ-009 SHALL have port event_ready, input, 1 bit: consumer accepts the event when event_valid and event_ready are both high.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-011 SHALL register button_pressed once (btn_q) and define press = button_pressed & ~btn_q, release = ~button_pressed & btn_q.
REQ-012 SHALL implement FSM states IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD with one shared cycle counter, sized by $clog2 of the largest parameter, cleared on every state change.
REQ-013 IDLE: on press -> PRESS1.
REQ-014 PRESS1: on release -> WAIT_GAP; when the counter reaches LONG_CYCLES-1 with the button still held -> generate LONG and go to LONG_HELD; release takes priority over LONG in the same cycle.
REQ-015 WAIT_GAP: on press -> PRESS2; when the counter reaches GAP_CYCLES-1 with no press -> generate SINGLE and go to IDLE; press takes priority in the same cycle.
REQ-016 PRESS2: on release -> generate DOUBLE and go to IDLE; when the counter reaches LONG_CYCLES-1 while held -> generate DOUBLE and go to LONG_HELD (no LONG event).
REQ-017 LONG_HELD: on release -> IDLE; no event is generated on that release.
REQ-018 A generated event SHALL appear on event_valid/event_code exactly one cycle after the deciding clock edge.
REQ-019 event_valid SHALL stay high and event_code stable until accepted; event_valid drops the cycle after acceptance unless a new event loads in that same cycle.
REQ-020 New event while valid & ~ready: the new event is dropped, the held event is kept, and overflow is set.
REQ-021 New event in the same cycle as acceptance: the new event loads and event_valid stays high; overflow is not set.
REQ-022 overflow SHALL clear only on reset.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state=IDLE, counter=0, btn_q=0, event_valid=0, event_code=00, overflow=0.
REQ-024 Reset asserted mid-press SHALL discard the gesture; a button already held at release of reset SHALL NOT produce a press until it is released and pressed again.
REQ-025 After rst_n deasserts, the first state update SHALL occur on the next rising clk edge.

Configuration
REQ-030 With macro BUTTON_AUTOREPEAT_EN defined, LONG_HELD SHALL generate an additional LONG event every REPEAT_CYCLES cycles while held, counting from entry to LONG_HELD; repeats follow REQ-018 to REQ-021.
REQ-031 Without BUTTON_AUTOREPEAT_EN, LONG_HELD SHALL generate no events and the REPEAT_CYCLES parameter SHALL be unused.

Verification (bench parameters LONG_CYCLES=20, GAP_CYCLES=8, REPEAT_CYCLES=5; event_ready=1 unless stated)
REQ-040 Press held 5 cycles, then released and idle 20 cycles -> exactly one event, code 01, valid 8 cycles after release (GAP_CYCLES after entry to WAIT_GAP).
REQ-041 Press 4, release 3, press 4, release -> exactly one event, code 10, one cycle after the second release edge.
REQ-042 Press held 30 cycles -> code 11 once, 20 cycles after the press edge, and nothing on release; with BUTTON_AUTOREPEAT_EN, two further 11 events at 5-cycle spacing.
REQ-043 event_ready=0, single then double gesture -> event_code holds 01, overflow=1; raising ready -> one handshake, then event_valid=0.
REQ-044 rst_n pulsed low during PRESS1 at counter=10 -> outputs zero immediately; button kept high through reset deassertion produces no events.
REQ-045 Acceptance and a new event in the same cycle -> event_valid stays 1, event_code updates, overflow remains 0.

Source files
------------

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into single, double and long press events held in a
// valid/ready output register. Define BUTTON_AUTOREPEAT_EN to repeat long events while held.
module button_event_classifier #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_pressed,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       overflow
);

  localparam int unsigned MaxLg     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCycles = (MaxLg > REPEAT_CYCLES) ? MaxLg : REPEAT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);
`endif

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeSingle = 2'b01;
  localparam logic [1:0] CodeDouble = 2'b10;
  localparam logic [1:0] CodeLong   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StWaitGap,
    StPress2,
    StLongHeld
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              btn_q;
  logic              armed_q;
  logic              event_valid_q;
  logic [1:0]        event_code_q;
  logic              overflow_q;

  logic              press;
  logic              release_evt;
  logic              gen;
  logic [1:0]        gen_code;
  logic              rep_wrap;

  // A button already held when reset lifts must be seen released before it can count as a press.
  assign press       = button_pressed & ~btn_q & armed_q;
  assign release_evt = ~button_pressed & btn_q;

  always_comb begin
    state_d  = state_q;
    gen      = 1'b0;
    gen_code = CodeNone;
    rep_wrap = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) state_d = StPress1;
      end
      StPress1: begin
        if (release_evt) begin
          state_d = StWaitGap;
        end else if (cnt_q == LongLast) begin
          gen      = 1'b1;
          gen_code = CodeLong;
          state_d  = StLongHeld;
        end
      end
      StWaitGap: begin
        if (press) begin
          state_d = StPress2;
        end else if (cnt_q == GapLast) begin
          gen      = 1'b1;
          gen_code = CodeSingle;
          state_d  = StIdle;
        end
      end
      StPress2: begin
        if (release_evt) begin
          gen      = 1'b1;
          gen_code = CodeDouble;
          state_d  = StIdle;
        end else if (cnt_q == LongLast) begin
          // A double click held long still reports as a double; no long event follows.
          gen      = 1'b1;
          gen_code = CodeDouble;
          state_d  = StLongHeld;
        end
      end
      StLongHeld: begin
        if (release_evt) begin
          state_d = StIdle;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        else if (cnt_q == RepeatLast) begin
          gen      = 1'b1;
          gen_code = CodeLong;
          rep_wrap = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if ((state_d != state_q) || rep_wrap || (state_q == StIdle)) begin
      cnt_d = '0;
    end
`ifndef BUTTON_AUTOREPEAT_EN
    else if (state_q == StLongHeld) begin
      cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q         <= 1'b0;
      armed_q       <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      event_valid_q <= 1'b0;
      event_code_q  <= CodeNone;
      overflow_q    <= 1'b0;
    end else begin
      btn_q   <= button_pressed;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!button_pressed) begin
        armed_q <= 1'b1;
      end
      // A new event may replace one being accepted this cycle; otherwise it is dropped.
      if (gen) begin
        if (!event_valid_q || event_ready) begin
          event_valid_q <= 1'b1;
          event_code_q  <= gen_code;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (event_ready) begin
        event_valid_q <= 1'b0;
      end
    end
  end

  assign event_valid = event_valid_q;
  assign event_code  = event_code_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier: a timestamp-based gesture model is compared with
// the DUT on every falling clock edge, with hand-computed expectations pinning the model.
module tb_button_event_classifier;

  localparam int unsigned LongC = 20;
  localparam int unsigned GapC  = 8;
  localparam int unsigned RepC  = 5;

  logic       clk;
  logic       rst_n;
  logic       button_pressed;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_code;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  button_event_classifier #(
    .LONG_CYCLES  (LongC),
    .GAP_CYCLES   (GapC),
    .REPEAT_CYCLES(RepC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button_pressed(button_pressed),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_ready   (event_ready),
    .overflow      (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (time %0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] at;
    logic [1:0]  code;
  } ev_t;

  ev_t         ev_q[$];
  int unsigned k       = 0;   // rising edges seen out of reset
  bit          m_prev  = 0;
  bit          m_armed = 0;
  int          presses = 0;   // presses in the gesture under way
  bit          held    = 0;
  bit          longm   = 0;
  int unsigned t_mark  = 0;   // edge of the last press, release or long decision
  bit          m_valid = 0;
  logic [1:0]  m_code  = 2'b00;
  bit          m_ovf   = 0;
  bit          mb, mpress, mrel;
  logic [1:0]  mev;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_prev = 0; m_armed = 0; presses = 0; held = 0; longm = 0;
        m_valid = 0; m_code = 2'b00; m_ovf = 0;
      end else begin
        k++;
        mb     = button_pressed;
        mpress = mb && !m_prev && m_armed;
        mrel   = !mb && m_prev;
        mev    = 2'b00;
        if (presses == 0) begin
          if (mpress) begin presses = 1; held = 1; t_mark = k; end
        end else if (longm) begin
          if (mrel) begin presses = 0; longm = 0; end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (k - t_mark == RepC) begin mev = 2'b11; t_mark = k; end
`endif
        end else if (held) begin
          if (mrel) begin
            if (presses == 2) begin mev = 2'b10; presses = 0; end
            else begin held = 0; t_mark = k; end
          end else if (k - t_mark == LongC) begin
            mev = (presses == 2) ? 2'b10 : 2'b11;
            longm = 1;
            t_mark = k;
          end
        end else begin
          if (mpress) begin presses = 2; held = 1; t_mark = k; end
          else if (k - t_mark == GapC) begin mev = 2'b01; presses = 0; end
        end
        if (mev != 2'b00) begin
          ev_q.push_back('{at: k, code: mev});
          if (!m_valid || event_ready) begin m_valid = 1; m_code = mev; end
          else m_ovf = 1;
        end else if (m_valid && event_ready) begin
          m_valid = 0;
        end
        m_prev = mb;
        if (!mb) m_armed = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_valid", {31'd0, event_valid}, {31'd0, m_valid});
      check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      if (m_valid) check("cyc_code", {30'd0, event_code}, {30'd0, m_code});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic until_edge(input int unsigned e);
    int guard = 0;
    while (k < e && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (k < e) begin
      errors++;
      $display("FAIL edge_wait got %0d expected %0d", k, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int unsigned p, r, r2;
    rst_n          = 1'b0;
    button_pressed = 1'b0;
    event_ready    = 1'b1;
    cycles(2);
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    check("rst_code", {30'd0, event_code}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // Single click: hold 5, release, event 8 edges after the release edge.
    ev_q.delete();
    button_pressed = 1; cycles(5); button_pressed = 0; r = k + 1;
    until_edge(r + 7);
    check("single_early", {31'd0, event_valid}, 32'd0);
    until_edge(r + 8);
    check("single_valid", {31'd0, event_valid}, 32'd1);
    check("single_code", {30'd0, event_code}, 32'd1);
    cycles(12);
    check("single_count", ev_q.size(), 32'd1);
    check("single_when", ev_q[0].at - r, 32'd8);
    check("single_mcode", {30'd0, ev_q[0].code}, 32'd1);

    // Double click: press 4, release 3, press 4, release.
    ev_q.delete();
    button_pressed = 1; cycles(4); button_pressed = 0; cycles(3);
    button_pressed = 1; cycles(4); button_pressed = 0; r2 = k + 1;
    check("double_early", {31'd0, event_valid}, 32'd0);
    until_edge(r2);
    check("double_valid", {31'd0, event_valid}, 32'd1);
    check("double_code", {30'd0, event_code}, 32'd2);
    cycles(20);
    check("double_count", ev_q.size(), 32'd1);
    check("double_when", ev_q[0].at, r2);

    // Long press held ~30 cycles.
    ev_q.delete();
    button_pressed = 1; p = k + 1; cycles(31); button_pressed = 0; r = k + 1;
    cycles(20);
`ifdef BUTTON_AUTOREPEAT_EN
    check("long_count", ev_q.size(), 32'd3);
    check("long_rep1", ev_q[1].at - ev_q[0].at, 32'd5);
    check("long_rep2", ev_q[2].at - ev_q[1].at, 32'd5);
`else
    check("long_count", ev_q.size(), 32'd1);
`endif
    check("long_when", ev_q[0].at - p, 32'd20);
    check("long_mcode", {30'd0, ev_q[0].code}, 32'd3);
    check("long_not_on_release", {31'd0, ev_q[ev_q.size() - 1].at < r}, 32'd1);

    // Consumer stalled: single is held, double is dropped, overflow sticks.
    event_ready = 0;
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(12);
    check("stall_single_code", {30'd0, event_code}, 32'd1);
    check("stall_no_ovf_yet", {31'd0, overflow}, 32'd0);
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(2);
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(3);
    check("stall_valid", {31'd0, event_valid}, 32'd1);
    check("stall_code_kept", {30'd0, event_code}, 32'd1);
    check("stall_overflow", {31'd0, overflow}, 32'd1);
    event_ready = 1; cycles(1);
    check("stall_drained", {31'd0, event_valid}, 32'd0);
    check("stall_ovf_sticky", {31'd0, overflow}, 32'd1);
    cycles(3);

    // Reset in the middle of a press, button held through reset release.
    ev_q.delete();
    button_pressed = 1; p = k + 1;
    until_edge(p + 10);
    #2 rst_n = 0;
    #1;
    check("midrst_valid", {31'd0, event_valid}, 32'd0);
    check("midrst_code", {30'd0, event_code}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    cycles(2);
    rst_n = 1;
    cycles(30); button_pressed = 0; cycles(20);
    check("midrst_no_events", ev_q.size(), 32'd0);

    // Acceptance and a new event on the same edge.
    event_ready = 0;
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(12);
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(2);
    button_pressed = 1; cycles(3); button_pressed = 0; event_ready = 1; r2 = k + 1;
    until_edge(r2);
    check("swap_valid", {31'd0, event_valid}, 32'd1);
    check("swap_code", {30'd0, event_code}, 32'd2);
    check("swap_overflow", {31'd0, overflow}, 32'd0);
    cycles(20);

    // Release on the same edge the long threshold is reached: release wins.
    ev_q.delete();
    button_pressed = 1; cycles(20); button_pressed = 0; r = k + 1;
    cycles(30);
    check("edge_long_count", ev_q.size(), 32'd1);
    check("edge_long_code", {30'd0, ev_q[0].code}, 32'd1);
    check("edge_long_when", ev_q[0].at - r, 32'd8);

    // Second press on the last gap edge: press wins over single.
    ev_q.delete();
    button_pressed = 1; cycles(2); button_pressed = 0; r = k + 1;
    until_edge(r + 7);
    button_pressed = 1; cycles(2); button_pressed = 0; r2 = k + 1;
    cycles(20);
    check("edge_gap_count", ev_q.size(), 32'd1);
    check("edge_gap_code", {30'd0, ev_q[0].code}, 32'd2);
    check("edge_gap_when", ev_q[0].at, r2);

    // Second press held past the long threshold: one double, nothing more.
    ev_q.delete();
    button_pressed = 1; cycles(3); button_pressed = 0; cycles(2);
    button_pressed = 1; p = k + 1; cycles(25); button_pressed = 0;
    cycles(20);
    check("dlong_count", ev_q.size(), 32'd1);
    check("dlong_code", {30'd0, ev_q[0].code}, 32'd2);
    check("dlong_when", ev_q[0].at - p, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
